// File: rtl/fp_cvt_pkg.sv
// Shared types and constants for the float-to-integer converter.
package fp_cvt_pkg;

  localparam int unsigned FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int unsigned FP_MANT_W  = 23;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } round_mode_e;

  typedef enum logic [2:0] {
    FC_ZERO = 3'd0,
    FC_SUB  = 3'd1,
    FC_NORM = 3'd2,
    FC_INF  = 3'd3,
    FC_NAN  = 3'd4
  } fp_class_e;

endpackage

// File: rtl/fp_cvt_round.sv
// Rounding-increment decision from sign, lsb, guard and sticky bits.
module fp_cvt_round
  import fp_cvt_pkg::*;
(
  input  logic        sign,
  input  logic        lsb,
  input  logic        g,
  input  logic        s,
  input  round_mode_e rm,
  output logic        incr
);

  // Select the increment rule for the active rounding mode
  always_comb begin
    incr = 1'b0;
    unique case (rm)
      RM_RNE:  incr = g & (s | lsb);
      RM_RTZ:  incr = 1'b0;
      RM_RDN:  incr = sign & (g | s);
      RM_RUP:  incr = ~sign & (g | s);
      default: incr = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_to_int_conv.sv
// Three-stage IEEE-754 single to signed/unsigned integer converter
// with rounding, saturation and invalid/inexact flags.
module fp_to_int_conv
  import fp_cvt_pkg::*;
#(
  parameter int unsigned INT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,        // asynchronous, active-high
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      fp_in,
  input  logic [1:0]       round_mode,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] int_out,
  output logic             flag_nv,
  output logic             flag_nx
);

  localparam int unsigned MANT_FULL_W = FP_MANT_W + 1;
  localparam int unsigned EXT_W       = MANT_FULL_W + 25;

  localparam logic [INT_W:0]   S_POS_LIM = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   S_NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] S_MAX     = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] S_MIN     = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] U_MAX     = {INT_W{1'b1}};

  // ---------------- stage registers ----------------
  logic                   s1_v_q, s1_v_d;
  logic                   s1_sign_q, s1_sign_d;
  logic [7:0]             s1_exp_q, s1_exp_d;
  logic [MANT_FULL_W-1:0] s1_mant_q, s1_mant_d;
  fp_class_e              s1_cls_q, s1_cls_d;
  round_mode_e            s1_rm_q, s1_rm_d;
  logic                   s1_sgn_q, s1_sgn_d;

  logic                   s2_v_q, s2_v_d;
  logic                   s2_sign_q, s2_sign_d;
  fp_class_e              s2_cls_q, s2_cls_d;
  round_mode_e            s2_rm_q, s2_rm_d;
  logic                   s2_sgn_q, s2_sgn_d;
  logic                   s2_ovf_q, s2_ovf_d;
  logic [INT_W-1:0]       s2_mag_q, s2_mag_d;
  logic                   s2_g_q, s2_g_d;
  logic                   s2_s_q, s2_s_d;

  logic                   out_valid_q, out_valid_d;
  logic [INT_W-1:0]       int_out_q, int_out_d;
  logic                   nv_q, nv_d;
  logic                   nx_q, nx_d;

  // ---------------- handshake chain ----------------
  logic s3_ready_c, s2_ready_c, s1_ready_c;

  // Each stage can load when empty or when its contents move on
  always_comb begin
    s3_ready_c = ~out_valid_q | out_ready;
    s2_ready_c = ~s2_v_q | s3_ready_c;
    s1_ready_c = ~s1_v_q | s2_ready_c;
  end

  assign in_ready  = s1_ready_c;
  assign out_valid = out_valid_q;
  assign int_out   = int_out_q;
  assign flag_nv   = nv_q;
  assign flag_nx   = nx_q;

  // ---------------- S1: unpack and classify ----------------
  logic [7:0]  in_exp_c;
  logic [22:0] in_frac_c;

  // Split the operand into fields and classify it
  always_comb begin
    in_exp_c  = fp_in[30:23];
    in_frac_c = fp_in[22:0];

    s1_v_d    = s1_v_q;
    s1_sign_d = s1_sign_q;
    s1_exp_d  = s1_exp_q;
    s1_mant_d = s1_mant_q;
    s1_cls_d  = s1_cls_q;
    s1_rm_d   = s1_rm_q;
    s1_sgn_d  = s1_sgn_q;

    if (s1_ready_c) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_sign_d = fp_in[31];
        s1_exp_d  = in_exp_c;
        s1_mant_d = {(in_exp_c != 8'd0), in_frac_c};
        s1_rm_d   = round_mode_e'(round_mode);
        s1_sgn_d  = is_signed;
        if (in_exp_c == FP_EXP_MAX)
          s1_cls_d = (in_frac_c != 23'd0) ? FC_NAN : FC_INF;
        else if (in_exp_c == 8'd0)
          s1_cls_d = (in_frac_c != 23'd0) ? FC_SUB : FC_ZERO;
        else
          s1_cls_d = FC_NORM;
      end
    end
  end

  // ---------------- S2: align mantissa ----------------
  logic signed [9:0]  unb_exp_c;
  logic [9:0]         sh_r_c;
  logic [6:0]         sh_l_c;
  logic [EXT_W-1:0]   ext_c;

  // Shift the mantissa to integer position, collecting guard and sticky
  always_comb begin
    unb_exp_c = $signed({2'b00, s1_exp_q}) - $signed(10'(FP_BIAS));
    sh_r_c    = 10'($signed(10'(FP_MANT_W)) - unb_exp_c);
    sh_l_c    = 7'(unb_exp_c - $signed(10'(FP_MANT_W)));
    ext_c     = {s1_mant_q, 25'd0} >> sh_r_c;

    s2_v_d    = s2_v_q;
    s2_sign_d = s2_sign_q;
    s2_cls_d  = s2_cls_q;
    s2_rm_d   = s2_rm_q;
    s2_sgn_d  = s2_sgn_q;
    s2_ovf_d  = s2_ovf_q;
    s2_mag_d  = s2_mag_q;
    s2_g_d    = s2_g_q;
    s2_s_d    = s2_s_q;

    if (s2_ready_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_sign_d = s1_sign_q;
        s2_cls_d  = s1_cls_q;
        s2_rm_d   = s1_rm_q;
        s2_sgn_d  = s1_sgn_q;
        s2_ovf_d  = 1'b0;
        s2_mag_d  = '0;
        s2_g_d    = 1'b0;
        s2_s_d    = 1'b0;
        if (unb_exp_c >= $signed(10'(INT_W))) begin
          s2_ovf_d = 1'b1;
        end else if (unb_exp_c >= $signed(10'(FP_MANT_W))) begin
          s2_mag_d = INT_W'(s1_mant_q) << sh_l_c;
        end else if (sh_r_c > 10'd25) begin
          s2_s_d = (s1_mant_q != '0);
        end else begin
          s2_mag_d = INT_W'(ext_c[EXT_W-1:25]);
          s2_g_d   = ext_c[24];
          s2_s_d   = |ext_c[23:0];
        end
      end
    end
  end

  // ---------------- S3: round and saturate ----------------
  logic             incr_c;
  logic [INT_W:0]   rnd_c;
  logic [INT_W-1:0] rnd_lo_c;
  logic             inexact_c;

  fp_cvt_round u_round (
    .sign (s2_sign_q),
    .lsb  (s2_mag_q[0]),
    .g    (s2_g_q),
    .s    (s2_s_q),
    .rm   (s2_rm_q),
    .incr (incr_c)
  );

  // Apply the rounding increment, range-check and produce the result
  always_comb begin
    rnd_c     = {1'b0, s2_mag_q} + (INT_W+1)'(incr_c);
    rnd_lo_c  = rnd_c[INT_W-1:0];
    inexact_c = s2_g_q | s2_s_q;

    out_valid_d = out_valid_q;
    int_out_d   = int_out_q;
    nv_d        = nv_q;
    nx_d        = nx_q;

    if (s3_ready_c) begin
      out_valid_d = s2_v_q;
      if (s2_v_q) begin
        nv_d = 1'b0;
        nx_d = 1'b0;
        if (s2_cls_q == FC_NAN) begin
          nv_d      = 1'b1;
          int_out_d = s2_sgn_q ? S_MAX : U_MAX;
        end else if (s2_cls_q == FC_INF || s2_ovf_q) begin
          nv_d = 1'b1;
          if (s2_sign_q) int_out_d = s2_sgn_q ? S_MIN : '0;
          else           int_out_d = s2_sgn_q ? S_MAX : U_MAX;
        end else if (s2_cls_q == FC_ZERO) begin
          int_out_d = '0;
        end else if (s2_sgn_q) begin
          if (!s2_sign_q && rnd_c > S_POS_LIM) begin
            nv_d      = 1'b1;
            int_out_d = S_MAX;
          end else if (s2_sign_q && rnd_c > S_NEG_LIM) begin
            nv_d      = 1'b1;
            int_out_d = S_MIN;
          end else begin
            nx_d      = inexact_c;
            int_out_d = s2_sign_q ? (~rnd_lo_c + INT_W'(1)) : rnd_lo_c;
          end
        end else begin
          if (s2_sign_q && rnd_c != '0) begin
            nv_d      = 1'b1;
            int_out_d = '0;
          end else if (rnd_c[INT_W]) begin
            nv_d      = 1'b1;
            int_out_d = U_MAX;
          end else begin
            nx_d      = inexact_c;
            int_out_d = rnd_lo_c;
          end
        end
      end
    end
  end

  // Pipeline state; reset drops every in-flight operation
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      s1_v_q      <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      s1_cls_q    <= FC_ZERO;
      s1_rm_q     <= RM_RNE;
      s1_sgn_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= FC_ZERO;
      s2_rm_q     <= RM_RNE;
      s2_sgn_q    <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_mag_q    <= '0;
      s2_g_q      <= 1'b0;
      s2_s_q      <= 1'b0;
      out_valid_q <= 1'b0;
      int_out_q   <= '0;
      nv_q        <= 1'b0;
      nx_q        <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
      s1_cls_q    <= s1_cls_d;
      s1_rm_q     <= s1_rm_d;
      s1_sgn_q    <= s1_sgn_d;
      s2_v_q      <= s2_v_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_rm_q     <= s2_rm_d;
      s2_sgn_q    <= s2_sgn_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_mag_q    <= s2_mag_d;
      s2_g_q      <= s2_g_d;
      s2_s_q      <= s2_s_d;
      out_valid_q <= out_valid_d;
      int_out_q   <= int_out_d;
      nv_q        <= nv_d;
      nx_q        <= nx_d;
    end
  end

endmodule
